conv_result_packer: RTL
=======================

# conv_result_packer

Producer side of the NPU convolution write-back interface. Takes one signed 16-bit convolution result per cycle from the conv datapath, requantizes it to INT8, and packs `LENGTH` consecutive results into one `LENGTH*INT8`-bit vector. It then presents the vector on `conv_v` with a single-cycle `conv_write` strobe, which is the form the result sink (memory write-back or `result.txt` dump) consumes.

## Interface
- `LENGTH`, default 16: lanes per output vector (from `def.v`).
- `INT8`, default 8: lane width in bits (from `def.v`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` input 1: `in_res` and `in_shift` are valid this cycle and are accepted. There is no backpressure.
- `in_res` input 16: signed conv accumulator result (`conv_res`).
- `in_shift` input 4: requant right-shift amount, 0..15, sampled with each `in_valid`.
- `flush` input 1: emit a partially filled vector.
- `conv_write` output 1: one-cycle strobe; `conv_v` is valid while it is high.
- `conv_v` output `LENGTH*INT8`: packed vector. Lane k occupies bits [8k+7:8k] (`index_k`).
- `lane_cnt` output 5: number of lanes currently filled, 0..15.
- `vec_cnt` output 16: number of vectors emitted; wraps from 0xFFFF to 0.

## Operation
- Requantization of each accepted sample, using a 17-bit signed intermediate:
  - if `in_shift`>0: t = (in_res + (1<<(in_shift-1))) >>> in_shift (round half up);
  - if `in_shift`=0: t = in_res.
  - Then saturate t to [-128, 127].
- Packing:
  - The first sample after reset or after an emit goes to lane 0, the next to lane 1, and so on.
  - The lane pointer is `lane_cnt`. It increments per accepted sample.
- Emit on full: when the 16th sample is accepted:
  - the assembled vector (including that sample) is loaded into `conv_v`;
  - `conv_write` pulses;
  - `lane_cnt` returns to 0 and `vec_cnt` increments.
- Emit on flush: `flush` with `lane_cnt`>0 emits the vector with all unfilled lanes zero.
- `flush` with `lane_cnt`=0 and no `in_valid` does nothing: no strobe, and `vec_cnt` is unchanged.
- Simultaneous `in_valid` and `flush`: the sample is packed first, then the vector is emitted. If the sample is the 16th, exactly one emit occurs.
- The staging buffer is cleared to zero on every emit, so stale lanes never leak into a partial vector.
- State: `FILL` (`lane_cnt`<16) is the only persistent state. `EMIT` is the single registered cycle in which `conv_write`=1. `FILL` continues during `EMIT`, so back-to-back input is never stalled.

## Timing
- Reset values: `conv_write`=0, `conv_v`=0, `lane_cnt`=0, `vec_cnt`=0, staging buffer=0.
- Latency: `conv_write` rises in the cycle after the edge that accepts the completing sample (or samples `flush`).
- `conv_v` holds its value until the next emit. It does not return to zero after the strobe.
- Throughput: 1 sample/cycle sustained. A new vector can complete every 16 cycles. A flush can emit on consecutive cycles if each cycle also accepts a sample.
- `conv_write` is never high for two consecutive cycles unless each of those cycles has its own emit condition.
- Reset asserted mid-vector: the partial vector is discarded without an emit, and all outputs return to reset values asynchronously.

## Configuration
- `CONV_RELU_EN`:
  - When defined, the saturated value is clamped to [0, 127] (ReLU fused before packing).
  - When undefined, signed INT8 [-128, 127] is packed unmodified.
  - The flag affects only requant; packing and timing are identical in both builds.

## Structure
- `def.v` supplies `LENGTH`, `INT8` and the `index_0`..`index_15` lane slice macros.
- `op_code.v` is not used.
- A combinational sub-module `conv_requant` (16-bit in, 4-bit shift, 8-bit out; round, saturate, optional ReLU) is instantiated once. The packer holds the counters, staging buffer and output register.

## Test plan
- 16 samples `in_res`=k (k=0..15) with `in_shift`=0 -> one `conv_write` one cycle after the 16th. `conv_v` = 0x0F0E0D0C0B0A09080706050403020100. `vec_cnt`=1.
- Saturation/rounding:
  - `in_res`=0x7FFF, `in_shift`=0 -> lane 0x7F;
  - `in_res`=0x8000 -> lane 0x80;
  - `in_res`=24, `in_shift`=4 -> 0x02 (1.5 rounds up);
  - `in_res`=-24, `in_shift`=4 -> 0xFF.
  - With `CONV_RELU_EN`, the negative cases give 0x00.
- 3 samples (5, 6, 7), then `flush` -> `conv_v`=0x...00070605 with upper 13 lanes zero. `lane_cnt` returns to 0. A second `flush` produces no strobe.
- 16th sample coincident with `flush` -> exactly one strobe, and `vec_cnt` increments by 1.
- 32 back-to-back samples -> strobes exactly 16 cycles apart with correct contents. `reset` low after sample 8 -> no strobe, and all outputs are 0 immediately.

Source files
------------

// File: rtl/conv_result_packer_pkg.sv
// Shared widths, FSM state type and INT8 saturation helper for the conv result packer.
package conv_result_packer_pkg;

   localparam int unsigned LENGTH_DEF = 16;
   localparam int unsigned INT8_DEF   = 8;
   localparam int unsigned RES_W      = 16;
   localparam int unsigned SHIFT_W    = 4;
   localparam int unsigned LANE_CNT_W = 5;
   localparam int unsigned VEC_CNT_W  = 16;

   typedef enum logic {
      FILL = 1'b0,
      EMIT = 1'b1
   } emit_state_t;

   function automatic logic [7:0] sat_int8(input logic signed [RES_W:0] t);
      if (t > 17'sd127) begin
         return 8'h7F;
      end else if (t < -17'sd128) begin
         return 8'h80;
      end else begin
         return t[7:0];
      end
   endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: round-half-up right shift, saturate to INT8.
// Define CONV_RELU_EN to clamp negative results to zero (fused ReLU).
module conv_requant
   import conv_result_packer_pkg::*;
(
   input  logic [RES_W-1:0]   res,
   input  logic [SHIFT_W-1:0] shift,
   output logic [7:0]         q
);

   logic signed [RES_W:0] ext;
   logic signed [RES_W:0] rnd;
   logic signed [RES_W:0] t;

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      ext = {res[RES_W-1], res};
      rnd = '0;
      if (shift != '0) begin
         rnd = 17'sd1 <<< (shift - 4'd1);
      end
      // 17 bits so +32767 plus the rounding constant cannot wrap negative.
      t = (ext + rnd) >>> shift;
      q = sat_int8(t);
`ifdef CONV_RELU_EN
      if (q[7]) begin
         q = 8'h00;
      end
`else
      q = q;
`endif
   end

endmodule

// File: rtl/conv_result_packer.sv
// Packs LENGTH requantized INT8 samples per vector and strobes conv_write for one cycle.
// The CONV_RELU_EN build option is handled inside conv_requant.
module conv_result_packer
   import conv_result_packer_pkg::*;
#(
   parameter int unsigned LENGTH = LENGTH_DEF,
   parameter int unsigned INT8   = INT8_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [RES_W-1:0]       in_res,
   input  logic [SHIFT_W-1:0]     in_shift,
   input  logic                   flush,
   output logic                   conv_write,
   output logic [LENGTH*INT8-1:0] conv_v,
   output logic [LANE_CNT_W-1:0]  lane_cnt,
   output logic [VEC_CNT_W-1:0]   vec_cnt
);

   localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LENGTH - 1);

   emit_state_t             state_q, state_d;
   logic [7:0]              lane_q;
   logic [LENGTH*INT8-1:0]  stage_q, stage_d, packed_v, conv_v_d;
   logic [LANE_CNT_W-1:0]   lane_cnt_d;
   logic [VEC_CNT_W-1:0]    vec_cnt_d;
   logic                    emit;

   conv_requant u_requant (
      .res   (in_res),
      .shift (in_shift),
      .q     (lane_q)
   );

   always_comb begin
      packed_v = stage_q;
      if (in_valid) begin
         for (int k = 0; k < int'(LENGTH); k++) begin
            if (lane_cnt == LANE_CNT_W'(k)) begin
               packed_v[k*INT8 +: INT8] = INT8'(lane_q);
            end
         end
      end

      // The incoming sample is packed before a flush, so a full+flush cycle emits once.
      emit = (in_valid && (lane_cnt == LAST_LANE)) ||
             (flush && (in_valid || (lane_cnt != '0)));

      stage_d    = packed_v;
      lane_cnt_d = lane_cnt + LANE_CNT_W'(in_valid);
      conv_v_d   = conv_v;
      vec_cnt_d  = vec_cnt;
      state_d    = FILL;
      if (emit) begin
         stage_d    = '0;
         lane_cnt_d = '0;
         conv_v_d   = packed_v;
         vec_cnt_d  = vec_cnt + 16'd1;
         state_d    = EMIT;
      end
   end

   // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
   // NOTE: the staging buffer is reset like any control register; a partial vector must never expose stale lanes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FILL;
         stage_q  <= '0;
         conv_v   <= '0;
         lane_cnt <= '0;
         vec_cnt  <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         conv_v   <= conv_v_d;
         lane_cnt <= lane_cnt_d;
         vec_cnt  <= vec_cnt_d;
      end
   end

   assign conv_write = (state_q == EMIT);

endmodule
